// File: rtl/iu_pkg.sv
// Shared types and elaboration helpers for the next-PC prediction unit.
package iu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_WORK = 3'b010,
        S_PUSH = 3'b100
    } state_t;

    // ceil(log2(v)); used on parameters only
    function automatic int ilog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/iu_btb.sv
// Direct-mapped branch target buffer: combinational lookup that falls back to
// the sequential PC, synchronous write port.
module iu_btb
    import iu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int STEP    = 4,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lk_pc,
    output logic [XLEN-1:0] lk_npc,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_tgt
);
    localparam int OFS_W = ilog2(STEP);
    localparam int IDX_W = ilog2(ENTRIES);
    localparam int TAG_W = XLEN - OFS_W - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, wr_idx;
    logic [TAG_W-1:0] lk_tag, wr_tag;
    logic             lk_hit;
    logic             wr_unused;

    assign lk_idx    = lk_pc[OFS_W +: IDX_W];
    assign lk_tag    = lk_pc[XLEN-1 -: TAG_W];
    assign wr_idx    = wr_pc[OFS_W +: IDX_W];
    assign wr_tag    = wr_pc[XLEN-1 -: TAG_W];
    assign wr_unused = ^wr_pc[OFS_W-1:0];

    // Reads see the array before this edge's write lands
    assign lk_hit = valid[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_npc = lk_hit ? tgt_q[lk_idx] : lk_pc + XLEN'(STEP);

    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_tgt;
        end
    end

endmodule

// File: rtl/iu_pred.sv
// Next-PC predictor: paced IDLE/WORK/PUSH loop feeding a prediction FIFO,
// with BTB-based lookup and miss-driven redirect/flush.
module iu_pred
    import iu_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter int          WORK_PERIOD = 6,
    parameter int          STEP        = 4,
    parameter int          BTB_ENTRIES = 16,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            miss,
    input  logic [XLEN-1:0] pc_curr,
    output logic [XLEN-1:0] pc_pre,
    output logic            pc_pre_oe,
    input  logic            pc_pre_rdy,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_tgt
);
    localparam int CNT_W = ilog2(WORK_PERIOD + 1);
    localparam int PTR_W = ilog2(FIFO_DEPTH);

    state_t           state;
    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  pred;
    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0]  fifo [FIFO_DEPTH];
    logic [PTR_W:0]   wptr, rptr;
    logic             empty, full, push, pop;

    // A miss redirects the single lookup port to the new base
    iu_btb #(.XLEN(XLEN), .STEP(STEP), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk    (clk),
        .rst    (rst),
        .lk_pc  (miss ? pc_curr : npc),
        .lk_npc (pred),
        .wr_en  (upd_en),
        .wr_pc  (upd_pc),
        .wr_tgt (upd_tgt)
    );

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign push  = (state == S_PUSH) && !full && !miss;
    assign pop   = pc_pre_oe && pc_pre_rdy && !miss;

    assign pc_pre_oe = !empty;
    assign pc_pre    = empty ? '0 : fifo[rptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            npc   <= XLEN'(RESET_PC);
            cnt   <= '0;
        end else if (miss) begin
            state <= S_WORK;
            npc   <= pred;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    npc   <= pred;
                    cnt   <= '0;
                    state <= S_WORK;
                end
                S_WORK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WORK_PERIOD - 1)) state <= S_PUSH;
                end
                S_PUSH: if (!full) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || miss) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo[wptr[PTR_W-1:0]] <= npc;
    end

endmodule
